// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encodings, constants and helpers for the fetch controller
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic misaligned(input logic [31:0] pc, input int unsigned step);
    return (step == 4) && (pc[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/fetch_ctrl_if_id_slot.sv
// if_id_slot: single-entry pipeline register with load/flush and valid/ready handshake
module if_id_slot #(
  parameter int          W   = 32,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_flush,
  input  logic [W-1:0] i_pc,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_data,
  output logic         o_xfer
);
  logic         r_valid;
  logic [W-1:0] r_pc;
  logic [W-1:0] r_data;

  assign o_xfer  = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_data  = r_data;

  // flush beats load; an accepted entry with no refill leaves the slot empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_data  <= NOP;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_data  <= NOP;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_data  <= i_data;
    end else if (o_xfer) begin
      r_valid <= 1'b0;
      r_data  <= NOP;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, IF/ID slot control, redirect/halt/fault FSM and fetch counter
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_count;
  logic        r_halted;
  logic        r_fault;
  logic        w_xfer;
  logic        w_fetch;
  logic        w_halt;
  logic        w_misal;
  logic        w_free;
  logic        w_load;
  logic        w_flush;

  assign w_fetch = r_state == S_FETCH;
  assign w_halt  = r_state == S_HALT;
  assign w_misal = misaligned(redirect_pc, PC_STEP);
  assign w_free  = !if_valid || id_ready;
  assign w_load  = w_fetch && !redirect_valid && !halt_req && w_free;
  assign w_flush = w_fetch && redirect_valid;

  assign imem_pc     = r_pc;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fetch_count = r_count;

  if_id_slot #(.W(32), .NOP(NOP_INSTR)) u_slot (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_flush(w_flush),
    .i_pc   (r_pc),
    .i_data (imem_instr),
    .i_ready(id_ready),
    .o_valid(if_valid),
    .o_pc   (if_pc),
    .o_data (if_instr),
    .o_xfer (w_xfer)
  );

  // controller FSM with PC, status flags and handshake counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_xfer) r_count <= r_count + 32'd1;
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (redirect_valid && w_misal) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else if (redirect_valid) begin
            r_pc <= redirect_pc;
          end else if (halt_req) begin
            if (w_free) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end else if (w_free) begin
            r_pc <= r_pc + 32'(PC_STEP);
          end
        end
        S_HALT: begin
          if (redirect_valid && w_misal) begin
            r_state  <= S_FAULT;
            r_fault  <= 1'b1;
            r_halted <= 1'b0;
          end else begin
            if (redirect_valid) r_pc <= redirect_pc;
            if (!halt_req) begin
              r_state  <= S_FETCH;
              r_halted <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_halt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a transfer scoreboard and point checks
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_pc, imem_instr, if_pc, if_instr, redirect_pc, fetch_count;
  logic        if_valid, id_ready, redirect_valid, halt_req, halted, fault;

  logic [31:0] w_pc, w_ifpc, w_ifinstr, w_cnt;
  logic        w_valid, w_halted, w_fault;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_instr = imem_pc >> 2;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .imem_pc(w_pc), .imem_instr(w_pc >> 2),
    .if_valid(w_valid), .if_pc(w_ifpc), .if_instr(w_ifinstr), .id_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt_req(1'b0),
    .halted(w_halted), .fault(w_fault), .fetch_count(w_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back({pc, pc >> 2});
  endtask

  // monitor: every handshake must match the next expected {pc, instr}
  always @(negedge clk) begin
    if (rst && if_valid && id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected got=%h/%h exp=none", if_pc, if_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          failures++;
          $display("FAIL xfer got=%h/%h exp=%h/%h", if_pc, if_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    step(2);
    chk("rst_valid", {31'd0, if_valid}, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_imem_pc", imem_pc, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_flags", {30'd0, halted, fault}, 0);
    rst = 1'b1;
    push(0); push(4); push(8); push(12);
    step(1);
    chk("boot_valid", {31'd0, if_valid}, 0);
    step(1);
    chk("first_valid", {31'd0, if_valid}, 1);
    chk("first_pc", if_pc, 0);
    chk("wrap_pc0", w_ifpc, 32'hFFFF_FFF8);
    step(1);
    chk("wrap_pc1", w_ifpc, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_pc2", w_ifpc, 32'h0);
    chk("wrap_instr2", w_ifinstr, 32'h0);
    step(2);
    chk("count4", fetch_count, 4);
    chk("pre_stall_imem", imem_pc, 20);
    id_ready = 1'b0;
    step(3);
    chk("stall_pc", if_pc, 16);
    chk("stall_instr", if_instr, 4);
    chk("stall_imem", imem_pc, 20);
    chk("stall_count", fetch_count, 4);
    push(16); push(20);
    id_ready = 1'b1;
    step(1);
    chk("resume_pc", if_pc, 20);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    chk("redir_flush", {31'd0, if_valid}, 0);
    chk("redir_nop", if_instr, NOP);
    chk("redir_imem", imem_pc, 32'h40);
    chk("redir_count", fetch_count, 6);
    push(32'h40); push(32'h44);
    step(1);
    chk("redir_first", if_pc, 32'h40);
    step(2);
    halt_req = 1'b1; id_ready = 1'b0;
    step(2);
    chk("halt_pending", {31'd0, if_valid}, 1);
    chk("halt_pending_pc", if_pc, 32'h48);
    chk("halt_not_yet", {31'd0, halted}, 0);
    push(32'h48);
    id_ready = 1'b1;
    step(1);
    chk("halted", {31'd0, halted}, 1);
    chk("halt_empty", {31'd0, if_valid}, 0);
    chk("halt_imem", imem_pc, 32'h4C);
    chk("halt_count", fetch_count, 9);
    step(2);
    chk("halt_hold", imem_pc, 32'h4C);
    chk("halt_still", {31'd0, halted}, 1);
    halt_req = 1'b0;
    push(32'h4C);
    step(1);
    chk("unhalt", {31'd0, halted}, 0);
    step(2);
    chk("resume_held", if_pc, 32'h50);
    chk("resume_count", fetch_count, 10);
    id_ready = 1'b0;
    step(2);
    chk("stall2_pc", if_pc, 32'h50);
    rst = 1'b0;
    step(1);
    chk("mrst_valid", {31'd0, if_valid}, 0);
    chk("mrst_pc", if_pc, 0);
    chk("mrst_instr", if_instr, NOP);
    chk("mrst_imem", imem_pc, 0);
    chk("mrst_count", fetch_count, 0);
    rst = 1'b1; id_ready = 1'b1;
    push(0); push(4);
    step(3);
    chk("mis_pre_pc", if_pc, 4);
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step(1);
    redirect_valid = 1'b0;
    chk("fault", {31'd0, fault}, 1);
    chk("fault_valid", {31'd0, if_valid}, 0);
    chk("fault_imem", imem_pc, 8);
    chk("fault_count", fetch_count, 2);
    step(3);
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(1);
    halt_req = 1'b0; redirect_valid = 1'b0;
    chk("fault_sticky", {31'd0, fault}, 1);
    chk("fault_ignore_redir", imem_pc, 8);
    chk("fault_ignore_halt", {31'd0, halted}, 0);
    chk("fault_still_empty", {31'd0, if_valid}, 0);
    rst = 1'b0;
    step(1);
    chk("fault_clear", {31'd0, fault}, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the instruction memory for the RISC-V core. It owns the PC register and drives the PC into inst_memory, which reads combinationally in the same cycle. It captures the returned instruction word into a single-entry IF/ID slot with a valid/ready handshake toward decode. It also handles branch/jump redirects, stalls, halt requests and misaligned-target faults, and keeps a fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, PC increment per fetched instruction, in bytes.
NOP_INSTR, 32'h0000_0013, value of if_instr whenever the slot is empty or reset (addi x0,x0,0).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
imem_pc  output  32  address to inst_memory; equals pc_q combinationally.
imem_instr  input  32  instruction word from inst_memory, valid in the same cycle.
if_valid  output  1  IF/ID slot holds a valid instruction.
if_pc  output  32  PC of the instruction in the slot.
if_instr  output  32  instruction in the slot.
id_ready  input  1  decode accepts the slot this cycle.
redirect_valid  input  1  branch/jump taken; load redirect_pc.
redirect_pc  input  32  redirect target.
halt_req  input  1  level; stop issuing new fetches.
halted  output  1  controller is in HALT.
fault  output  1  sticky misaligned-redirect fault.
fetch_count  output  32  number of completed IF/ID handshakes.

Behaviour:
- Reset (rst==0 at posedge):
  - pc_q=RESET_PC, state=IDLE.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR.
  - halted=0, fault=0, fetch_count=0.
  - Reset wins over every other input, including when asserted mid-stall or while in HALT/FAULT.
- States: IDLE, FETCH, HALT, FAULT.
- IDLE: one boot cycle with no fetch, then FETCH unconditionally.
- Handshake:
  - A transfer occurs in a cycle where if_valid && id_ready.
  - fetch_count increments by 1 on each transfer and wraps modulo 2^32.
- FETCH, slot load:
  - The slot is free when !if_valid || id_ready.
  - If the slot is free: slot <= {pc_q, imem_instr}, if_valid<=1, pc_q<=pc_q+PC_STEP.
  - Fetch latency is one cycle: PC is presented in cycle N, and the instruction appears on if_* in cycle N+1.
- FETCH, stall:
  - If if_valid && !id_ready: pc_q, if_pc, if_instr and if_valid hold.
  - imem_pc stays stable.
- PC arithmetic: 32-bit, wraps naturally (32'hFFFF_FFFC+4 -> 0).
- Redirect:
  - Priority over a normal slot load.
  - pc_q<=redirect_pc, if_valid<=0, if_instr<=NOP_INSTR.
  - A transfer in the same cycle still completes and is counted.
  - The first redirected instruction appears on if_* two cycles after redirect_valid.
- Misaligned redirect:
  - Applies when redirect_pc[1:0]!=0 and PC_STEP==4.
  - Go to FAULT: fault<=1, if_valid<=0, pc_q unchanged.
  - FAULT exits only on reset.
- halt_req in FETCH:
  - No new slot loads.
  - The pending slot remains until accepted.
  - Enter HALT on the cycle the slot becomes empty (immediately if already empty); halted<=1.
  - pc_q holds the next unfetched PC.
- halt_req together with redirect_valid: the redirect updates pc_q and flushes the slot first, then the controller enters HALT the next cycle.
- HALT:
  - Exits to FETCH when halt_req deasserts; halted<=0 on that transition.
  - Fetching resumes from the held pc_q.
  - redirect_valid in HALT updates pc_q (or faults if misaligned) without leaving HALT.
- redirect_valid and halt_req in IDLE or FAULT are ignored.

Decomposition:
- Shared header fetch_defs.vh:
  - state encodings (IDLE=2'd0, FETCH=2'd1, HALT=2'd2, FAULT=2'd3);
  - NOP_INSTR constant;
  - default RESET_PC.
- One sub-module: if_id_slot.
  - Single-entry register with load/hold/flush controls and valid/ready handshake.
  - Reused later for other pipeline boundaries.
- PC register, FSM and counter stay in fetch_ctrl.

Test Plan:
- Reset then free-run: rst=0 for 2 cycles, then 1; id_ready=1; memory word[i]=i -> if_valid first high 2 cycles after release; if_pc sequence 0,4,8,12; fetch_count=4 after four transfers.
- Stall: id_ready=0 for 3 cycles with if_pc=8 -> if_pc, if_instr and imem_pc (=12) hold; fetch_count unchanged; resumes at 12 when id_ready=1.
- Redirect: redirect_valid=1, redirect_pc=32'h40 while if_pc=8 -> if_valid=0 next cycle; next valid if_pc=0x40, then 0x44.
- Misaligned redirect to 32'h42 -> fault=1 and if_valid=0 from the next cycle; FAULT persists; only rst=0 clears it.
- Halt with a pending slot: halt_req=1, id_ready=0 for 2 cycles, then 1 -> slot accepted; halted=1 the following cycle; pc_q holds; halt_req=0 -> fetch resumes at the held PC.
- Wrap and mid-operation reset: RESET_PC=32'hFFFF_FFF8 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; then rst=0 during a stall -> all outputs at their reset values the next cycle.
